// File: rtl/vx_socket_mem_mux_if.sv
// Socket <-> L2 memory bus bundle for the cluster memory mux.
// The mux takes the slave view; the environment (sockets + L2) takes the master view.
interface vx_socket_mem_mux_if #(
  parameter int NUM_INPUTS = 4,
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_SIZE  = 64,
  parameter int TAG_WIDTH  = 8
);
  localparam int SEL_BITS      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 0;
  localparam int OUT_TAG_WIDTH = TAG_WIDTH + SEL_BITS;

  // socket side
  logic [NUM_INPUTS-1:0]                  in_req_valid;
  logic [NUM_INPUTS-1:0]                  in_req_rw;
  logic [NUM_INPUTS-1:0][ADDR_WIDTH-1:0]  in_req_addr;
  logic [NUM_INPUTS-1:0][DATA_SIZE-1:0]   in_req_byteen;
  logic [NUM_INPUTS-1:0][DATA_SIZE*8-1:0] in_req_data;
  logic [NUM_INPUTS-1:0][TAG_WIDTH-1:0]   in_req_tag;
  logic [NUM_INPUTS-1:0]                  in_req_ready;
  logic [NUM_INPUTS-1:0]                  in_rsp_valid;
  logic [NUM_INPUTS-1:0][DATA_SIZE*8-1:0] in_rsp_data;
  logic [NUM_INPUTS-1:0][TAG_WIDTH-1:0]   in_rsp_tag;
  logic [NUM_INPUTS-1:0]                  in_rsp_ready;

  // L2 side
  logic                     out_req_valid;
  logic                     out_req_rw;
  logic [ADDR_WIDTH-1:0]    out_req_addr;
  logic [DATA_SIZE-1:0]     out_req_byteen;
  logic [DATA_SIZE*8-1:0]   out_req_data;
  logic [OUT_TAG_WIDTH-1:0] out_req_tag;
  logic                     out_req_ready;
  logic                     out_rsp_valid;
  logic [DATA_SIZE*8-1:0]   out_rsp_data;
  logic [OUT_TAG_WIDTH-1:0] out_rsp_tag;
  logic                     out_rsp_ready;

  modport slave (
    input  in_req_valid, in_req_rw, in_req_addr, in_req_byteen, in_req_data, in_req_tag,
    output in_req_ready,
    output in_rsp_valid, in_rsp_data, in_rsp_tag,
    input  in_rsp_ready,
    output out_req_valid, out_req_rw, out_req_addr, out_req_byteen, out_req_data, out_req_tag,
    input  out_req_ready,
    input  out_rsp_valid, out_rsp_data, out_rsp_tag,
    output out_rsp_ready
  );

  modport master (
    output in_req_valid, in_req_rw, in_req_addr, in_req_byteen, in_req_data, in_req_tag,
    input  in_req_ready,
    input  in_rsp_valid, in_rsp_data, in_rsp_tag,
    output in_rsp_ready,
    input  out_req_valid, out_req_rw, out_req_addr, out_req_byteen, out_req_data, out_req_tag,
    output out_req_ready,
    output out_rsp_valid, out_rsp_data, out_rsp_tag,
    input  out_rsp_ready
  );
endinterface

// File: rtl/vx_socket_mem_mux.sv
// Cluster memory mux: round-robin merge of per-socket request streams into one
// L2 stream (socket index appended to tag LSBs), index-routed response return,
// and per-socket outstanding-read credits.

// Per-socket outstanding-read counter.
module vx_socket_mem_mux_credit #(
  parameter int MAX_PENDING = 16,
  parameter int CW          = $clog2(MAX_PENDING + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic inc_i,
  input  logic dec_i,
  output logic full_o,
  output logic nz_o
);
  logic [CW-1:0] cnt_q, cnt_d;

  // inc+dec together holds; a stray response at zero saturates instead of wrapping
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i)                     cnt_d = cnt_q + CW'(1);
    else if (dec_i && !inc_i && cnt_q != '0) cnt_d = cnt_q - CW'(1);
  end

  // counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign full_o = (cnt_q >= CW'(MAX_PENDING));
  assign nz_o   = (cnt_q != '0);
endmodule

module vx_socket_mem_mux #(
  parameter int NUM_INPUTS  = 4,
  parameter int ADDR_WIDTH  = 26,
  parameter int DATA_SIZE   = 64,
  parameter int TAG_WIDTH   = 8,
  parameter int MAX_PENDING = 16
) (
  input  logic               clk,
  input  logic               reset,
  vx_socket_mem_mux_if.slave bus,
  output logic               busy
);
  localparam int SEL_BITS      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 0;
  localparam int SELW          = (SEL_BITS > 0) ? SEL_BITS : 1;
  localparam int OUT_TAG_WIDTH = TAG_WIDTH + SEL_BITS;

  typedef struct packed {
    logic                     rw;
    logic [ADDR_WIDTH-1:0]    addr;
    logic [DATA_SIZE-1:0]     byteen;
    logic [DATA_SIZE*8-1:0]   data;
    logic [OUT_TAG_WIDTH-1:0] tag;
  } req_t;

  logic [NUM_INPUTS-1:0] elig, cred_full, cred_nz, rsp_vld_vec;
  logic [SELW-1:0]       rr_q, rr_d, win;
  logic                  any_elig, grant, push, pop;
  logic [1:0]            cnt_q, cnt_d;
  logic                  wp_q, rp_q;
  req_t                  mem_q [2];
  req_t                  push_req, head;
  logic [OUT_TAG_WIDTH-1:0] push_tag;

  logic                   rsp_vld_q, rsp_load, rsp_drain;
  logic [SELW-1:0]        rsp_sel_q, rsp_sel_in;
  logic [TAG_WIDTH-1:0]   rsp_tag_q;
  logic [DATA_SIZE*8-1:0] rsp_data_q;

  // reads at the credit limit are masked; writes never need credit
  always_comb begin
    for (int i = 0; i < NUM_INPUTS; i++)
      elig[i] = bus.in_req_valid[i] & (bus.in_req_rw[i] | ~cred_full[i]);
  end

  // round-robin pick: first eligible input at or after the pointer
  always_comb begin
    win      = '0;
    any_elig = 1'b0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (!any_elig && elig[(int'(rr_q) + k) % NUM_INPUTS]) begin
        any_elig = 1'b1;
        win      = SELW'((int'(rr_q) + k) % NUM_INPUTS);
      end
    end
  end

  // grant only into a non-full buffer; grant is the input handshake
  assign grant = any_elig & (cnt_q != 2'd2) & ~reset;
  assign push  = grant;
  assign pop   = (cnt_q != 2'd0) & bus.out_req_ready;

  always_comb begin
    for (int i = 0; i < NUM_INPUTS; i++)
      bus.in_req_ready[i] = grant & (win == SELW'(i));
  end

  // socket index rides in the tag LSBs when there is more than one socket
  if (SEL_BITS > 0) begin : g_idx
    assign push_tag   = {bus.in_req_tag[win], win};
    assign rsp_sel_in = bus.out_rsp_tag[SEL_BITS-1:0];
  end else begin : g_noidx
    assign push_tag   = bus.in_req_tag[win];
    assign rsp_sel_in = '0;
  end

  // pack the winning request
  always_comb begin
    push_req.rw     = bus.in_req_rw[win];
    push_req.addr   = bus.in_req_addr[win];
    push_req.byteen = bus.in_req_byteen[win];
    push_req.data   = bus.in_req_data[win];
    push_req.tag    = push_tag;
  end

  // pointer advances past the winner only on a handshake; buffer occupancy
  always_comb begin
    rr_d = rr_q;
    if (grant) rr_d = (win == SELW'(NUM_INPUTS - 1)) ? '0 : win + SELW'(1);
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // arbiter and request buffer control state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q  <= '0;
      cnt_q <= 2'd0;
      wp_q  <= 1'b0;
      rp_q  <= 1'b0;
    end else begin
      rr_q  <= rr_d;
      cnt_q <= cnt_d;
      if (push) wp_q <= ~wp_q;
      if (pop)  rp_q <= ~rp_q;
    end
  end

  // request payload storage; qualified by cnt_q so it needs no reset
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= push_req;
  end

  assign head               = mem_q[rp_q];
  assign bus.out_req_valid  = (cnt_q != 2'd0);
  assign bus.out_req_rw     = head.rw;
  assign bus.out_req_addr   = head.addr;
  assign bus.out_req_byteen = head.byteen;
  assign bus.out_req_data   = head.data;
  assign bus.out_req_tag    = head.tag;

  // response stage accepts when empty or draining this cycle
  assign rsp_drain         = rsp_vld_q & bus.in_rsp_ready[rsp_sel_q];
  assign bus.out_rsp_ready = ~reset & (~rsp_vld_q | rsp_drain);
  assign rsp_load          = bus.out_rsp_valid & bus.out_rsp_ready;

  // response stage valid
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          rsp_vld_q <= 1'b0;
    else if (rsp_load)  rsp_vld_q <= 1'b1;
    else if (rsp_drain) rsp_vld_q <= 1'b0;
  end

  // response stage payload, index stripped from the tag
  always_ff @(posedge clk) begin
    if (rsp_load) begin
      rsp_sel_q  <= rsp_sel_in;
      rsp_tag_q  <= bus.out_rsp_tag[OUT_TAG_WIDTH-1:SEL_BITS];
      rsp_data_q <= bus.out_rsp_data;
    end
  end

  // only the addressed socket sees valid; data/tag are broadcast
  always_comb begin
    for (int i = 0; i < NUM_INPUTS; i++)
      rsp_vld_vec[i] = rsp_vld_q & (rsp_sel_q == SELW'(i));
  end
  assign bus.in_rsp_valid = rsp_vld_vec;
  assign bus.in_rsp_tag   = {NUM_INPUTS{rsp_tag_q}};
  assign bus.in_rsp_data  = {NUM_INPUTS{rsp_data_q}};

  for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_cred
    vx_socket_mem_mux_credit #(.MAX_PENDING(MAX_PENDING)) u_cred (
      .clk    (clk),
      .reset  (reset),
      .inc_i  (grant & ~bus.in_req_rw[win] & (win == SELW'(g))),
      .dec_i  (rsp_vld_vec[g] & bus.in_rsp_ready[g]),
      .full_o (cred_full[g]),
      .nz_o   (cred_nz[g])
    );
  end

  assign busy = (|cred_nz) | (cnt_q != 2'd0) | rsp_vld_q;

  // an L2 response must belong to a socket with a read outstanding
  rsp_credit_chk: assert property (@(posedge clk) disable iff (reset)
    rsp_load |-> cred_nz[rsp_sel_in]);
endmodule

// File: tb/tb_vx_socket_mem_mux.sv
// Randomized + directed bench for vx_socket_mem_mux against a queue-based model.
module tb_vx_socket_mem_mux;
  localparam int N = 4, AW = 26, DS = 4, TW = 8, MP = 2, DW = DS * 8;

  logic clk = 1'b0;
  logic reset;
  logic busy;

  vx_socket_mem_mux_if #(.NUM_INPUTS(N), .ADDR_WIDTH(AW), .DATA_SIZE(DS), .TAG_WIDTH(TW)) bus ();

  vx_socket_mem_mux #(.NUM_INPUTS(N), .ADDR_WIDTH(AW), .DATA_SIZE(DS), .TAG_WIDTH(TW),
                      .MAX_PENDING(MP)) dut (
    .clk(clk), .reset(reset), .bus(bus), .busy(busy));

  always #5 clk = ~clk;

  typedef struct { bit rw; bit [AW-1:0] addr; bit [DS-1:0] be; bit [DW-1:0] data; bit [TW-1:0] tag; int port; } mreq_t;
  typedef struct { bit [DW-1:0] data; bit [TW-1:0] tag; int port; } mrsp_t;

  mreq_t reqq[$];    // requests accepted, not yet taken by L2 (max 2)
  mrsp_t rspq[$];    // response held for a socket (max 1)
  mrsp_t l2pend[$];  // reads the L2 owes a response for
  int    gq[$];      // ports in L2 issue order
  int    rr, last_win, start;
  int    cred[N];
  bit    taken, last_acc;
  int    n_tot = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    reqq.delete(); rspq.delete(); l2pend.delete();
    rr = 0;
    for (int i = 0; i < N; i++) cred[i] = 0;
  endtask

  task automatic idle();
    bus.in_req_valid = '0;
    bus.in_req_rw    = '0;
  endtask

  task automatic set_req(input int p, input bit rw, input logic [AW-1:0] a, input logic [TW-1:0] t);
    bus.in_req_valid[p]  = 1'b1;
    bus.in_req_rw[p]     = rw;
    bus.in_req_addr[p]   = a;
    bus.in_req_tag[p]    = t;
    bus.in_req_data[p]   = $urandom;
    bus.in_req_byteen[p] = DS'($urandom);
  endtask

  // L2 returns one owed read response (oldest, or random pick)
  task automatic l2_drive(input bit rnd);
    int idx;
    mrsp_t e;
    if (!bus.out_rsp_valid && l2pend.size() > 0 && (!rnd || $urandom_range(0, 1) == 1)) begin
      idx = rnd ? int'($urandom_range(0, l2pend.size() - 1)) : 0;
      e = l2pend[idx];
      l2pend.delete(idx);
      bus.out_rsp_valid = 1'b1;
      bus.out_rsp_tag   = {e.tag, 2'(e.port)};
      bus.out_rsp_data  = e.data;
    end
  endtask

  // one clock: check outputs against the model, then advance the model at the edge.
  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic cyc();
    int win;
    bit acc, ordy, eb;
    logic [N-1:0] erdy, erv;
    mreq_t h, e;
    mrsp_t r;
    #1;
    win = -1;
    for (int k = 0; k < N; k++)
      if (win < 0 && bus.in_req_valid[(rr + k) % N] &&
          (bus.in_req_rw[(rr + k) % N] || cred[(rr + k) % N] < MP)) win = (rr + k) % N;
    acc  = (win >= 0) && (reqq.size() < 2);
    erdy = acc ? (N'(1) << win) : '0;
    chk("in_req_ready", bus.in_req_ready, erdy);
    chk("out_req_valid", bus.out_req_valid, reqq.size() != 0);
    if (reqq.size() != 0) begin
      chk("out_req_tag", bus.out_req_tag, {reqq[0].tag, 2'(reqq[0].port)});
      chk("out_req_fields", {bus.out_req_rw, bus.out_req_addr, bus.out_req_byteen, bus.out_req_data},
          {reqq[0].rw, reqq[0].addr, reqq[0].be, reqq[0].data});
    end
    ordy = (rspq.size() == 0) || bus.in_rsp_ready[rspq[0].port];
    chk("out_rsp_ready", bus.out_rsp_ready, ordy);
    erv = (rspq.size() != 0) ? (N'(1) << rspq[0].port) : '0;
    chk("in_rsp_valid", bus.in_rsp_valid, erv);
    if (rspq.size() != 0) begin
      chk("in_rsp_tag", bus.in_rsp_tag[rspq[0].port], rspq[0].tag);
      chk("in_rsp_data", bus.in_rsp_data[rspq[0].port], rspq[0].data);
    end
    eb = (reqq.size() != 0) || (rspq.size() != 0);
    for (int i = 0; i < N; i++) if (cred[i] > 0) eb = 1'b1;
    chk("busy", busy, eb);

    @(posedge clk);
    if (reqq.size() != 0 && bus.out_req_ready) begin
      h = reqq.pop_front();
      gq.push_back(h.port);
      if (!h.rw) begin
        r.tag = h.tag; r.port = h.port; r.data = $urandom;
        l2pend.push_back(r);
      end
    end
    last_acc = acc;
    if (acc) begin
      e.rw = bus.in_req_rw[win]; e.addr = bus.in_req_addr[win]; e.be = bus.in_req_byteen[win];
      e.data = bus.in_req_data[win]; e.tag = bus.in_req_tag[win]; e.port = win;
      reqq.push_back(e);
      if (!e.rw) cred[win]++;
      rr = (win + 1) % N;
      last_win = win;
    end
    if (rspq.size() != 0 && bus.in_rsp_ready[rspq[0].port]) begin
      if (cred[rspq[0].port] > 0) cred[rspq[0].port]--;
      void'(rspq.pop_front());
    end
    if (bus.out_rsp_valid && ordy) begin
      r.tag = bus.out_rsp_tag[TW+1:2]; r.port = int'(bus.out_rsp_tag[1:0]); r.data = bus.out_rsp_data;
      rspq.push_back(r);
      taken = 1'b1;
    end
    @(negedge clk);
    if (taken) begin
      bus.out_rsp_valid = 1'b0;
      taken = 1'b0;
    end
  endtask

  task automatic drain();
    int b;
    b = 0;
    idle();
    bus.in_rsp_ready  = '1;
    bus.out_req_ready = 1'b1;
    while ((reqq.size() != 0 || rspq.size() != 0 || l2pend.size() != 0 || bus.out_rsp_valid) && b < 100) begin
      l2_drive(0);
      cyc();
      b++;
    end
    chk("drain_in_time", b < 100, 1'b1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    taken = 1'b0;
    bus.in_req_valid = '1; bus.in_req_rw = '1;
    bus.in_req_addr = '0; bus.in_req_byteen = '0; bus.in_req_data = '0; bus.in_req_tag = '0;
    bus.in_rsp_ready = '1; bus.out_req_ready = 1'b1;
    bus.out_rsp_valid = 1'b0; bus.out_rsp_tag = '0; bus.out_rsp_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_in_req_ready", bus.in_req_ready, 0);
    chk("rst_out_req_valid", bus.out_req_valid, 0);
    chk("rst_in_rsp_valid", bus.in_rsp_valid, 0);
    chk("rst_busy", busy, 0);
    idle();
    reset = 1'b0;

    // single read round trip
    set_req(0, 1'b0, 26'h100, 8'h5A);
    cyc();
    idle();
    #1 chk("t1_out_valid", bus.out_req_valid, 1);
    chk("t1_out_tag", bus.out_req_tag, 10'h168);
    cyc();
    l2_drive(0);
    cyc();
    #1 chk("t1_rsp_valid", bus.in_rsp_valid, 4'b0001);
    chk("t1_rsp_tag", bus.in_rsp_tag[0], 8'h5A);
    cyc();
    chk("t1_busy_clear", busy, 0);

    // fairness with a 3-cycle L2 stall; every input holds a write
    gq.delete();
    start = rr;
    for (int p = 0; p < N; p++) set_req(p, 1'b1, AW'(p * 4), TW'(p));
    for (int c = 0; c < 12; c++) begin
      bus.out_req_ready = !(c >= 4 && c < 7);
      cyc();
      if (last_acc) bus.in_req_data[last_win] = $urandom;
    end
    drain();
    chk("rr_count", gq.size(), 9);
    for (int j = 0; j < gq.size(); j++) chk("rr_order", gq[j], (start + j) % N);

    // credit limit on port 1
    set_req(1, 1'b0, 26'h200, 8'h11);
    cyc();
    bus.in_req_tag[1] = 8'h12;
    cyc();
    bus.in_req_tag[1] = 8'h13;
    #1 chk("t3_read_blocked", bus.in_req_ready[1], 0);
    cyc();
    bus.in_req_rw[1] = 1'b1;
    #1 chk("t3_write_ok", bus.in_req_ready[1], 1);
    cyc();
    bus.in_req_rw[1] = 1'b0;
    cyc();
    l2_drive(0);
    cyc();
    cyc();
    #1 chk("t3_read_freed", bus.in_req_ready[1], 1);
    cyc();
    drain();

    // response backpressure on port 2 with port 3 queued behind
    set_req(2, 1'b0, 26'h300, 8'h22); cyc(); idle();
    set_req(3, 1'b0, 26'h304, 8'h33); cyc(); idle();
    cyc(); cyc();
    bus.in_rsp_ready = 4'b1011;
    l2_drive(0); cyc();
    l2_drive(0);
    #1 chk("t4_rsp_stall", bus.out_rsp_ready, 0);
    cyc(); cyc();
    bus.in_rsp_ready = '1;
    cyc();
    #1 chk("t4_p3_valid", bus.in_rsp_valid, 4'b1000);
    chk("t4_p3_tag", bus.in_rsp_tag[3], 8'h33);
    cyc();
    drain();

    // read accept and response handshake on port 0 in the same cycle
    bus.in_rsp_ready = 4'b1110;
    set_req(0, 1'b0, 26'h400, 8'h44); cyc(); idle();
    cyc(); cyc();
    l2_drive(0); cyc();
    set_req(0, 1'b0, 26'h404, 8'h45);
    bus.in_rsp_ready = '1;
    cyc();
    bus.in_req_tag[0] = 8'h46;
    cyc();
    bus.in_req_tag[0] = 8'h47;
    #1 chk("t5_limit", bus.in_req_ready[0], 0);
    cyc();
    drain();

    // asynchronous reset with the request buffer full
    bus.out_req_ready = 1'b0;
    set_req(0, 1'b0, 26'h500, 8'h55); cyc(); idle();
    set_req(1, 1'b0, 26'h504, 8'h56); cyc();
    bus.in_req_valid = '1;
    #2 reset = 1'b1;
    #1 chk("t6_out_valid", bus.out_req_valid, 0);
    chk("t6_in_rsp_valid", bus.in_rsp_valid, 0);
    chk("t6_in_req_ready", bus.in_req_ready, 0);
    chk("t6_busy", busy, 0);
    model_reset();
    bus.out_rsp_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    idle();
    reset = 1'b0;
    bus.out_req_ready = 1'b1;
    repeat (4) cyc();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < N; p++) begin
        bus.in_req_valid[p]  = $urandom_range(0, 1) == 1;
        bus.in_req_rw[p]     = $urandom_range(0, 3) == 0;
        bus.in_req_addr[p]   = AW'($urandom);
        bus.in_req_tag[p]    = TW'($urandom);
        bus.in_req_data[p]   = $urandom;
        bus.in_req_byteen[p] = DS'($urandom);
      end
      bus.out_req_ready = $urandom_range(0, 3) != 0;
      bus.in_rsp_ready  = N'($urandom);
      l2_drive(1);
      cyc();
    end
    drain();
    chk("end_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
